// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide block: op codes, divide FSM states
// and the default operand width / divide step count.
package md_pkg;

    localparam int MD_WIDTH     = 32;
    localparam int MD_DIV_STEPS = MD_WIDTH;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/div_core.sv
// Iterative unsigned restoring divider: one quotient bit per clock, WIDTH steps after start.
// done is high during the cycle whose closing edge performs the final step.
module div_core
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        shifted = {rem_q, quo_q[WIDTH-1]};
        // The difference always fits WIDTH bits whenever the subtract is taken.
        trial   = shifted[WIDTH-1:0] - dvs_q;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CNT_W'(WIDTH - 1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = trial;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign done      = run_q && (cnt_q == '0);

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register block: captures multiplier products, services MTHI/MTLO and sequences
// signed/unsigned divides through div_core with a sign fix-up cycle before write-back.
module hilo_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               op_valid,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   rs_val,
    input  logic [WIDTH-1:0]   rt_val,
    input  logic [2*WIDTH-1:0] mul_prod,
    output logic               op_ready,
    output logic               busy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo
);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic             div0_q, div0_d;

    logic             accept;
    logic             div_start;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_done;

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (dvd_mag),
        .divisor   (dvs_mag),
        .quotient  (quotient),
        .remainder (remainder),
        .done      (div_done)
    );

    assign busy     = (state_q != S_IDLE);
    assign op_ready = ~busy;
    assign accept   = op_valid && op_ready;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rs_d      = rs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        div_start = 1'b0;
        dvd_mag   = rs_val;
        dvs_mag   = rt_val;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        MD_MULT, MD_MULTU: {hi_d, lo_d} = mul_prod;
                        MD_MTHI:           hi_d = rs_val;
                        MD_MTLO:           lo_d = rs_val;
                        MD_DIV, MD_DIVU: begin
                            // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
                            if (op == MD_DIV) begin
                                dvd_mag   = rs_val[WIDTH-1] ? -rs_val : rs_val;
                                dvs_mag   = rt_val[WIDTH-1] ? -rt_val : rt_val;
                                quo_neg_d = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
                                rem_neg_d = rs_val[WIDTH-1];
                            end else begin
                                quo_neg_d = 1'b0;
                                rem_neg_d = 1'b0;
                            end
                            rs_d      = rs_val;
                            div0_d    = (rt_val == '0);
                            div_start = 1'b1;
                            state_d   = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (div_done) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (div0_q) begin
                    lo_d = '1;
                    hi_d = rs_q;
                end else begin
                    lo_d = quo_neg_q ? -quotient : quotient;
                    hi_d = rem_neg_q ? -remainder : remainder;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            rs_q      <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rs_q      <= rs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed corner cases plus randomized ops against
// an arithmetic reference model of HI/LO.
module tb_hilo_unit;
    import md_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset;
    logic           op_valid;
    logic [2:0]     op;
    logic [W-1:0]   rs_val;
    logic [W-1:0]   rt_val;
    logic [2*W-1:0] mul_prod;
    logic           op_ready;
    logic           busy;
    logic [W-1:0]   hi;
    logic [W-1:0]   lo;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] m_hi;
    logic [W-1:0] m_lo;

    hilo_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mul_prod (mul_prod),
        .op_ready (op_ready),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // inj >= 0: attempt an MTLO of 0x55 that many cycles into the busy window.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] p, input int inj);
        logic [31:0] q, r, hi0, lo0;
        int n;
        bit stable;
        op       = o;
        rs_val   = a;
        rt_val   = b;
        mul_prod = p;
        op_valid = 1'b1;
        chk({tag, "_ready"}, op_ready, 1);
        hi0 = m_hi;
        lo0 = m_lo;
        tick();
        op_valid = 1'b0;
        mul_prod = {$urandom, $urandom};
        case (o)
            3'd0, 3'd1: {m_hi, m_lo} = p;
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            3'd2: begin ref_div(1'b1, a, b, q, r); m_lo = q; m_hi = r; end
            3'd3: begin ref_div(1'b0, a, b, q, r); m_lo = q; m_hi = r; end
            default: ;
        endcase
        if (o == 3'd2 || o == 3'd3) begin
            n = 0;
            stable = 1'b1;
            while (busy && n < 40) begin
                if (hi !== hi0 || lo !== lo0) stable = 1'b0;
                if (n == inj) begin
                    op       = 3'd5;
                    rs_val   = 32'h55;
                    op_valid = 1'b1;
                    chk({tag, "_busy_ready"}, op_ready, 0);
                end else begin
                    op_valid = 1'b0;
                end
                n++;
                tick();
            end
            op_valid = 1'b0;
            chk({tag, "_busy_cycles"}, n, 33);
            chk({tag, "_hold"}, stable, 1);
        end else begin
            chk({tag, "_busy"}, busy, 0);
        end
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [2:0]  o;
        logic [31:0] a, b;
        logic [63:0] p;

        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        rs_val   = '0;
        rt_val   = '0;
        mul_prod = '0;
        m_hi     = '0;
        m_lo     = '0;
        tick();
        tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", op_ready, 1);
        reset = 1'b0;

        run_op("mult", 3'd0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, -1);
        run_op("divu_100_7", 3'd3, 32'd100, 32'd7, 64'd0, -1);
        run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0, -1);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, -1);
        run_op("div_5_0", 3'd2, 32'd5, 32'd0, 64'd0, -1);
        run_op("divu_9_0", 3'd3, 32'd9, 32'd0, 64'd0, -1);
        run_op("div_neg0", 3'd2, 32'hFFFF_FFF0, 32'd0, 64'd0, -1);
        run_op("div_drop", 3'd3, 32'd1000, 32'd3, 64'd0, 5);

        // Abort a divide with reset on its tenth edge.
        op       = 3'd3;
        rs_val   = 32'd1000;
        rt_val   = 32'd3;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", op_ready, 1);
        run_op("mthi_ab", 3'd4, 32'hAB, 32'd0, 64'd0, -1);
        run_op("mtlo_rnd", 3'd5, $urandom, 32'd0, 64'd0, -1);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
            if (o == 3'd0)
                p = 64'(longint'($signed(a)) * longint'($signed(b)));
            else if (o == 3'd1)
                p = {32'd0, a} * {32'd0, b};
            else
                p = {$urandom, $urandom};
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b, p, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
